sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-request SDRAM controller.
// Each port owns one pending slot; accesses are issued one at a time with an optional WAIT timeout.
module sdram_port_arbiter #(
  parameter int ADDR_BITS      = 23,
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   p0_read_en,
  input  logic                   p0_write_en,
  input  logic [ADDR_BITS-1:0]   p0_addr,
  input  logic [XLEN/8-1:0]      p0_byte_enable,
  input  logic [XLEN-1:0]        p0_write_data,
  output logic                   p0_ack,
  output logic [XLEN-1:0]        p0_read_data,
  input  logic                   p1_read_en,
  input  logic                   p1_write_en,
  input  logic [ADDR_BITS-1:0]   p1_addr,
  input  logic [XLEN/8-1:0]      p1_byte_enable,
  input  logic [XLEN-1:0]        p1_write_data,
  output logic                   p1_ack,
  output logic [XLEN-1:0]        p1_read_data,
  output logic                   mem_cs,
  output logic                   mem_read0_write1,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [XLEN/8-1:0]      mem_byteenable,
  output logic [XLEN-1:0]        mem_write_data,
  input  logic                   mem_ack,
  input  logic [XLEN-1:0]        mem_read_data,
  output logic                   grant_p1,
  output logic                   busy,
  output logic                   protocol_error,
  output logic                   timeout_error
);

  localparam int BE    = XLEN / 8;
  localparam int CW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TO_M1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TO_LAST = TO_M1[CW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t               state_q, state_d;
  logic [1:0]           rd_en, wr_en, inflight;
  logic [ADDR_BITS-1:0] addr_in [2];
  logic [BE-1:0]        be_in   [2];
  logic [XLEN-1:0]      wdata_in[2];

  logic [1:0]           pend_q, pend_d, we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q [2], addr_d [2];
  logic [BE-1:0]        be_q   [2], be_d   [2];
  logic [XLEN-1:0]      wdata_q[2], wdata_d[2];
  logic                 last_q, last_d, grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mem_cs_q, mem_cs_d, mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [BE-1:0]        mem_be_q, mem_be_d;
  logic [XLEN-1:0]      mem_wdata_q, mem_wdata_d;
  logic [1:0]           ack_q, ack_d;
  logic [XLEN-1:0]      rdata_q[2], rdata_d[2];
  logic                 perr_q, perr_d, terr_q, terr_d;
  logic                 win;

  assign rd_en       = {p1_read_en, p0_read_en};
  assign wr_en       = {p1_write_en, p0_write_en};
  assign addr_in[0]  = p0_addr;
  assign addr_in[1]  = p1_addr;
  assign be_in[0]    = p0_byte_enable;
  assign be_in[1]    = p1_byte_enable;
  assign wdata_in[0] = p0_write_data;
  assign wdata_in[1] = p1_write_data;
  // The granted port stays busy from ISSUE until the cycle after its completion.
  assign inflight    = (state_q != S_IDLE) ? {grant_q, ~grant_q} : 2'b00;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    last_d      = last_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    mem_cs_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    perr_d      = perr_q;
    terr_d      = terr_q;
    win         = 1'b0;

    for (int unsigned p = 0; p < 2; p++) begin
      if (rd_en[p] || wr_en[p]) begin
        if (rd_en[p] && wr_en[p]) perr_d = 1'b1;
        if (pend_q[p] || inflight[p]) begin
          perr_d = 1'b1;
        end else begin
          pend_d[p]  = 1'b1;
          we_d[p]    = wr_en[p];
          addr_d[p]  = addr_in[p];
          be_d[p]    = be_in[p];
          wdata_d[p] = wdata_in[p];
        end
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (|pend_q) begin
          win         = (pend_q == 2'b11) ? ~last_q : pend_q[1];
          state_d     = S_ISSUE;
          mem_cs_d    = 1'b1;
          mem_we_d    = we_q[win];
          mem_addr_d  = addr_q[win];
          mem_be_d    = be_q[win];
          mem_wdata_d = wdata_q[win];
          pend_d[win] = 1'b0;
          last_d      = win;
          grant_d     = win;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (mem_ack) begin
          ack_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = mem_read_data;
          state_d          = S_IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          ack_d[grant_q]   = 1'b1;
          rdata_d[grant_q] = '0;
          terr_d           = 1'b1;
          state_d          = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      we_q        <= '0;
      addr_q      <= '{default: '0};
      be_q        <= '{default: '0};
      wdata_q     <= '{default: '0};
      last_q      <= 1'b1;
      grant_q     <= 1'b0;
      cnt_q       <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      ack_q       <= '0;
      rdata_q     <= '{default: '0};
      perr_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      perr_q      <= perr_d;
      terr_q      <= terr_d;
    end
  end

  assign p0_ack           = ack_q[0];
  assign p1_ack           = ack_q[1];
  assign p0_read_data     = rdata_q[0];
  assign p1_read_data     = rdata_q[1];
  assign mem_cs           = mem_cs_q;
  assign mem_read0_write1 = mem_we_q;
  assign mem_addr         = mem_addr_q;
  assign mem_byteenable   = mem_be_q;
  assign mem_write_data   = mem_wdata_q;
  assign grant_p1         = grant_q;
  assign busy             = (state_q != S_IDLE);
  assign protocol_error   = perr_q;
  assign timeout_error    = terr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a timestamp-based transaction model.
module tb_sdram_port_arbiter;
  localparam int AW = 23;
  localparam int XL = 32;
  localparam int BW = XL / 8;
  localparam int TO = 8;

  logic          clk, areset;
  logic          p0_read_en, p0_write_en, p1_read_en, p1_write_en;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [BW-1:0] p0_byte_enable, p1_byte_enable;
  logic [XL-1:0] p0_write_data, p1_write_data;
  logic          p0_ack, p1_ack;
  logic [XL-1:0] p0_read_data, p1_read_data;
  logic          mem_cs, mem_read0_write1;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_byteenable;
  logic [XL-1:0] mem_write_data;
  logic          mem_ack;
  logic [XL-1:0] mem_read_data;
  logic          grant_p1, busy, protocol_error, timeout_error;

  sdram_port_arbiter #(.ADDR_BITS(AW), .XLEN(XL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .areset(areset),
    .p0_read_en(p0_read_en), .p0_write_en(p0_write_en), .p0_addr(p0_addr),
    .p0_byte_enable(p0_byte_enable), .p0_write_data(p0_write_data),
    .p0_ack(p0_ack), .p0_read_data(p0_read_data),
    .p1_read_en(p1_read_en), .p1_write_en(p1_write_en), .p1_addr(p1_addr),
    .p1_byte_enable(p1_byte_enable), .p1_write_data(p1_write_data),
    .p1_ack(p1_ack), .p1_read_data(p1_read_data),
    .mem_cs(mem_cs), .mem_read0_write1(mem_read0_write1), .mem_addr(mem_addr),
    .mem_byteenable(mem_byteenable), .mem_write_data(mem_write_data),
    .mem_ack(mem_ack), .mem_read_data(mem_read_data),
    .grant_p1(grant_p1), .busy(busy),
    .protocol_error(protocol_error), .timeout_error(timeout_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int mc     = 0;

  // Model: each access is a timestamped transaction; issue time = max(arrival+2, completion+2).
  bit            m_pend[2], m_we[2];
  logic [AW-1:0] m_addr[2];
  logic [BW-1:0] m_be[2];
  logic [XL-1:0] m_wd[2];
  int            m_arr[2];
  bit            m_act, m_own, m_last;
  int            m_issue, m_free;
  bit            e_cs, e_we, e_grant, e_busy, e_perr, e_terr;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_be;
  logic [XL-1:0] e_wd;
  bit            e_ack[2];
  logic [XL-1:0] e_rd[2];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, mc);
    end
  endfunction

  function automatic void model_reset();
    m_pend = '{default: 0};
    m_act = 0; m_own = 0; m_last = 1; m_issue = 0; m_free = 0;
    e_cs = 0; e_we = 0; e_grant = 0; e_busy = 0; e_perr = 0; e_terr = 0;
    e_addr = '0; e_be = '0; e_wd = '0;
    e_ack = '{default: 0};
    e_rd = '{default: '0};
  endfunction

  function automatic void compare_outputs();
    chk("mem_cs", 64'(mem_cs), 64'(e_cs));
    chk("mem_read0_write1", 64'(mem_read0_write1), 64'(e_we));
    chk("mem_addr", 64'(mem_addr), 64'(e_addr));
    chk("mem_byteenable", 64'(mem_byteenable), 64'(e_be));
    chk("mem_write_data", 64'(mem_write_data), 64'(e_wd));
    chk("p0_ack", 64'(p0_ack), 64'(e_ack[0]));
    chk("p1_ack", 64'(p1_ack), 64'(e_ack[1]));
    chk("grant_p1", 64'(grant_p1), 64'(e_grant));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("protocol_error", 64'(protocol_error), 64'(e_perr));
    chk("timeout_error", 64'(timeout_error), 64'(e_terr));
    if (e_ack[0]) chk("p0_read_data", 64'(p0_read_data), 64'(e_rd[0]));
    if (e_ack[1]) chk("p1_read_data", 64'(p1_read_data), 64'(e_rd[1]));
  endfunction

  // Consumes the inputs of cycle c and produces the expected outputs of cycle c+1.
  function automatic void model_step(int c);
    bit ren[2], wen[2], ackn[2], elig[2];
    bit w;
    ren[0] = p0_read_en; wen[0] = p0_write_en;
    ren[1] = p1_read_en; wen[1] = p1_write_en;
    ackn = '{default: 0};
    for (int p = 0; p < 2; p++) begin
      if (ren[p] || wen[p]) begin
        if (ren[p] && wen[p]) e_perr = 1;
        if (m_pend[p] || (m_act && int'(m_own) == p)) begin
          e_perr = 1;
        end else begin
          m_pend[p] = 1;
          m_we[p]   = wen[p];
          m_addr[p] = (p == 0) ? p0_addr : p1_addr;
          m_be[p]   = (p == 0) ? p0_byte_enable : p1_byte_enable;
          m_wd[p]   = (p == 0) ? p0_write_data : p1_write_data;
          m_arr[p]  = c;
        end
      end
    end
    if (m_act && c > m_issue) begin
      if (mem_ack) begin
        ackn[m_own] = 1; e_rd[m_own] = mem_read_data; m_act = 0; m_free = c + 2;
      end else if (TO != 0 && c - m_issue == TO) begin
        ackn[m_own] = 1; e_rd[m_own] = '0; e_terr = 1; m_act = 0; m_free = c + 2;
      end
    end
    e_cs = 0;
    if (!m_act && m_free <= c + 1) begin
      for (int p = 0; p < 2; p++) elig[p] = m_pend[p] && (m_arr[p] + 2 <= c + 1);
      if (elig[0] || elig[1]) begin
        w = (elig[0] && elig[1]) ? !m_last : elig[1];
        m_last = w; m_pend[w] = 0; m_act = 1; m_own = w; m_issue = c + 1;
        e_cs = 1; e_we = m_we[w]; e_addr = m_addr[w]; e_be = m_be[w]; e_wd = m_wd[w];
        e_grant = w;
      end
    end
    e_ack  = ackn;
    e_busy = m_act;
  endfunction

  always @(negedge clk) begin
    if (areset) begin
      model_reset();
      compare_outputs();
    end else begin
      compare_outputs();
      model_step(mc);
    end
    mc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    p0_read_en = 0; p0_write_en = 0; p1_read_en = 0; p1_write_en = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    areset = 1;
    tick();
    tick();
    areset = 0;
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_p1), 64'd0);
    chk("rst_perr", 64'(protocol_error), 64'd0);
    chk("rst_terr", 64'(timeout_error), 64'd0);
  endtask

  int nack, ncs;

  initial begin
    areset = 1;
    p0_read_en = 0; p0_write_en = 0; p1_read_en = 0; p1_write_en = 0;
    p0_addr = '0; p1_addr = '0; p0_byte_enable = '0; p1_byte_enable = '0;
    p0_write_data = '0; p1_write_data = '0; mem_ack = 0; mem_read_data = '0;
    do_reset();

    // Single read: mem_cs two cycles after the request, ack the cycle after mem_ack.
    p0_read_en = 1; p0_addr = 23'h000100; p0_byte_enable = 4'hF;
    tick(); chk("rd_cs_early", 64'(mem_cs), 64'd0);
    tick();
    chk("rd_cs", 64'(mem_cs), 64'd1);
    chk("rd_type", 64'(mem_read0_write1), 64'd0);
    chk("rd_addr", 64'(mem_addr), 64'h100);
    tick(); tick(); tick();
    mem_ack = 1; mem_read_data = 32'hCAFEF00D;
    tick();
    chk("rd_ack", 64'(p0_ack), 64'd1);
    chk("rd_data", 64'(p0_read_data), 64'hCAFEF00D);
    chk("rd_other_ack", 64'(p1_ack), 64'd0);
    tick(); chk("rd_ack_pulse", 64'(p0_ack), 64'd0);

    // Simultaneous writes: p0 wins first tie, p1 follows 2 cycles after mem_ack.
    do_reset();
    p0_write_en = 1; p0_addr = 23'h000A00; p0_write_data = 32'h11110000; p0_byte_enable = 4'hF;
    p1_write_en = 1; p1_addr = 23'h000B00; p1_write_data = 32'h22220000; p1_byte_enable = 4'h3;
    tick(); tick();
    chk("tie1_cs", 64'(mem_cs), 64'd1);
    chk("tie1_grant", 64'(grant_p1), 64'd0);
    chk("tie1_type", 64'(mem_read0_write1), 64'd1);
    chk("tie1_addr", 64'(mem_addr), 64'hA00);
    chk("tie1_wdata", 64'(mem_write_data), 64'h11110000);
    tick(); tick(); mem_ack = 1;
    tick();
    chk("tie1_p0_ack", 64'(p0_ack), 64'd1);
    chk("tie1_cs_gap", 64'(mem_cs), 64'd0);
    tick();
    chk("tie1_p1_cs", 64'(mem_cs), 64'd1);
    chk("tie1_p1_grant", 64'(grant_p1), 64'd1);
    chk("tie1_p1_addr", 64'(mem_addr), 64'hB00);
    chk("tie1_p1_be", 64'(mem_byteenable), 64'h3);
    tick(); mem_ack = 1;
    tick(); chk("tie1_p1_ack", 64'(p1_ack), 64'd1);
    p0_read_en = 1; p0_addr = 23'h000C00;
    tick(); tick();
    chk("solo_p0_grant", 64'(grant_p1), 64'd0);
    tick(); mem_ack = 1;
    tick(); chk("solo_p0_ack", 64'(p0_ack), 64'd1);
    // p0 was last granted, so this tie goes to p1.
    p0_write_en = 1; p0_addr = 23'h000D00;
    p1_write_en = 1; p1_addr = 23'h000E00;
    tick(); tick();
    chk("tie2_cs", 64'(mem_cs), 64'd1);
    chk("tie2_grant", 64'(grant_p1), 64'd1);
    chk("tie2_addr", 64'(mem_addr), 64'hE00);
    tick(); mem_ack = 1;
    tick(); chk("tie2_p1_ack", 64'(p1_ack), 64'd1);
    tick();
    chk("tie2_p0_grant", 64'(grant_p1), 64'd0);
    chk("tie2_p0_addr", 64'(mem_addr), 64'hD00);

    // Timeout after TO WAIT cycles; returns zero data and ignores a late mem_ack.
    do_reset();
    p0_read_en = 1; p0_addr = 23'h000077; mem_read_data = 32'hDEADBEEF;
    tick();
    repeat (9) tick();
    chk("to_no_ack_yet", 64'(p0_ack), 64'd0);
    chk("to_busy", 64'(busy), 64'd1);
    tick();
    chk("to_ack", 64'(p0_ack), 64'd1);
    chk("to_rdata", 64'(p0_read_data), 64'd0);
    chk("to_err", 64'(timeout_error), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    mem_ack = 1;
    tick(); chk("to_late_ack", 64'(p0_ack), 64'd0);
    tick(); chk("to_late_ack2", 64'(p0_ack), 64'd0);

    // Re-request while pending is dropped and flagged; exactly one ack.
    do_reset();
    p1_write_en = 1; p1_addr = 23'h000F00;
    tick();
    chk("pe_before", 64'(protocol_error), 64'd0);
    p1_read_en = 1;
    tick();
    chk("pe_set", 64'(protocol_error), 64'd1);
    chk("pe_cs", 64'(mem_cs), 64'd1);
    tick(); mem_ack = 1;
    nack = 0; ncs = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      nack += int'(p1_ack);
      ncs  += int'(mem_cs);
    end
    chk("pe_single_ack", 64'(nack), 64'd1);
    chk("pe_no_reissue", 64'(ncs), 64'd0);

    // read_en and write_en together: treated as a write, flagged.
    do_reset();
    p0_read_en = 1; p0_write_en = 1; p0_addr = 23'h000123;
    tick(); chk("both_perr", 64'(protocol_error), 64'd1);
    tick(); chk("both_type", 64'(mem_read0_write1), 64'd1);

    // Asynchronous reset during WAIT clears outputs at once; no ack afterwards.
    do_reset();
    p0_read_en = 1; p0_addr = 23'h000055; p0_byte_enable = 4'hA;
    tick(); tick(); tick();
    chk("ar_busy", 64'(busy), 64'd1);
    #1 areset = 1;
    #1;
    chk("ar_busy0", 64'(busy), 64'd0);
    chk("ar_addr0", 64'(mem_addr), 64'd0);
    chk("ar_be0", 64'(mem_byteenable), 64'd0);
    chk("ar_cs0", 64'(mem_cs), 64'd0);
    tick();
    areset = 0; mem_ack = 1; mem_read_data = 32'h55AA55AA;
    tick(); chk("ar_no_ack", 64'(p0_ack), 64'd0);
    tick(); chk("ar_no_ack2", 64'(p0_ack), 64'd0);

    // Randomized traffic, all checking done by the per-cycle model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 600 == 599) do_reset();
      for (int p = 0; p < 2; p++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (p == 0) begin
          p0_read_en  = (r < 15) || (r >= 30 && r < 32);
          p0_write_en = (r >= 15 && r < 32);
          p0_addr = AW'($urandom()); p0_byte_enable = BW'($urandom()); p0_write_data = $urandom();
        end else begin
          p1_read_en  = (r < 15) || (r >= 30 && r < 32);
          p1_write_en = (r >= 15 && r < 32);
          p1_addr = AW'($urandom()); p1_byte_enable = BW'($urandom()); p1_write_data = $urandom();
        end
      end
      mem_ack = ($urandom_range(0, 99) < 25);
      mem_read_data = $urandom();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
